control_sequencer: RTL and testbench

//  Parametrised multi-cycle successor to the combinational opcode decoder.
//  - Accepts instructions over a valid/ready handshake and decodes the ALU operation.
//  - Sequences DECODE/EXEC/WAIT/WB, holding the core for multi-cycle MUL/DIV.
//  - Sits between the instruction source and the ALU + register file; counts retired instructions.

---
 rtl/control_sequencer.sv | 167 ++++++++++++++++
 tb/tb_control_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/DECODE/EXEC/WAIT/WB (+TRAP), registered outputs, retire counter.
// Define ILLEGAL_TRAP_EN to trap on undefined opcodes; otherwise they execute as ADD.
module control_sequencer #(
  parameter int INSTR_W    = 8,
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 2,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_W-1:0]    instruction,
  output logic [2:0]            alu_op_select,
  output logic                  alu_sub,
  output logic                  alu_en,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic                  reg_we,
  output logic                  busy,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int WAIT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [OPCODE_W-1:0] OPC_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OPC_MUL   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OPC_DIV   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OPC_UNDEF = OPCODE_W'(6);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD = WAIT_W'(MULDIV_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_WB, S_TRAP
  } state_t;

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   opc_q, opc_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [2:0]            op_q, op_d;
  logic                  sub_q, sub_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, busy_q, en_q, we_q;
  logic                  is_muldiv;

  // Undefined opcodes decode as ADD in both builds.
  function automatic logic [2:0] decode_op(input logic [OPCODE_W-1:0] opc);
    if (opc < OPC_UNDEF) return 3'(opc);
    return 3'b000;
  endfunction

  assign is_muldiv = (opc_q == OPC_MUL) || (opc_q == OPC_DIV);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    wait_d  = wait_q;
    op_d    = op_q;
    sub_d   = sub_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Fields decode straight from the input so they are visible in DECODE.
        if (instr_valid && ready_q) begin
          opc_d   = instruction[INSTR_W-1 -: OPCODE_W];
          op_d    = decode_op(opc_d);
          sub_d   = (opc_d == OPC_SUB);
          rd_d    = instruction[2*REG_ADDR_W-1:REG_ADDR_W];
          rs_d    = instruction[REG_ADDR_W-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (opc_q >= OPC_UNDEF) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
`endif
      end
      S_EXEC: begin
        if (is_muldiv) begin
          state_d = S_WAIT;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = S_WB;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_WB;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output strobes are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      wait_q  <= '0;
      op_q    <= '0;
      sub_q   <= 1'b0;
      rd_q    <= '0;
      rs_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      en_q    <= (state_d == S_EXEC);
      we_q    <= (state_d == S_WB);
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign instr_ready   = ready_q;
  assign busy          = busy_q;
  assign alu_en        = en_q;
  assign reg_we        = we_q;
  assign alu_op_select = op_q;
  assign alu_sub       = sub_q;
  assign rd_addr       = rd_q;
  assign rs_addr       = rs_q;
  assign instr_count   = cnt_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a transaction-timeline reference model.
module tb_control_sequencer;
  localparam int MULDIV_LAT = 4;
  localparam int NCYC       = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, instr_valid;
  logic [7:0] instruction;

  logic        rdy, sub, en, we, bsy, ill;
  logic [2:0]  op;
  logic [1:0]  rd, rs;
  logic [15:0] cnt;

  logic        rdy2, sub2, en2, we2, bsy2, ill2;
  logic [2:0]  op2;
  logic [1:0]  rd2, rs2;
  logic [1:0]  cnt2;

  control_sequencer #(.MULDIV_LAT(MULDIV_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy),
    .instruction(instruction), .alu_op_select(op), .alu_sub(sub), .alu_en(en),
    .rd_addr(rd), .rs_addr(rs), .reg_we(we), .busy(bsy), .illegal(ill),
    .instr_count(cnt)
  );

  control_sequencer #(.MULDIV_LAT(MULDIV_LAT), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy2),
    .instruction(instruction), .alu_op_select(op2), .alu_sub(sub2), .alu_en(en2),
    .rd_addr(rd2), .rs_addr(rs2), .reg_we(we2), .busy(bsy2), .illegal(ill2),
    .instr_count(cnt2)
  );

  int tests_run = 0;
  int failures  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: an accepted instruction occupies the cycles after acceptance.
  // Offset 1 = decode, 2 = ALU launch, len = write-back, then idle again.
  bit  rst_prev, have, trap, e_ill, div_rst_done;
  int  t_acc, len, cur_opc, count;
  int  e_op, e_sub, e_rd, e_rs;
  bit  x_rdy, x_bsy, x_en, x_we, rst, acc;
  int  k, opc;
  logic [7:0] dq[$];

  initial begin
    dq = '{8'h06, 8'h1B, 8'h2D, 8'h3E, 8'h40, 8'h50, 8'hF7, 8'h01, 8'h02, 8'h03};
    reset = 1'b1; instr_valid = 1'b0; instruction = 8'h00;
    rst_prev = 1'b1; have = 1'b0; trap = 1'b0; e_ill = 1'b0; div_rst_done = 1'b0;
    t_acc = 0; len = 0; cur_opc = 0; count = 0;
    e_op = 0; e_sub = 0; e_rd = 0; e_rs = 0;
    @(posedge clk);
    for (int n = 1; n < NCYC; n++) begin
      @(negedge clk);
      k = 0;
      if (rst_prev) begin
        have = 1'b0; trap = 1'b0; e_ill = 1'b0; count = 0;
        e_op = 0; e_sub = 0; e_rd = 0; e_rs = 0;
        x_rdy = 1'b0; x_bsy = 1'b0; x_en = 1'b0; x_we = 1'b0;
      end else if (!have) begin
        x_rdy = 1'b1; x_bsy = 1'b0; x_en = 1'b0; x_we = 1'b0;
      end else begin
        k = n - t_acc;
        x_rdy = 1'b0; x_bsy = 1'b1;
        x_en  = (k == 2) && !trap;
        x_we  = (k == len) && !trap;
        if (trap && k >= 2) e_ill = 1'b1;
        if (x_we) count++;
      end

      check("instr_ready", 32'(rdy), 32'(x_rdy));
      check("busy", 32'(bsy), 32'(x_bsy));
      check("alu_en", 32'(en), 32'(x_en));
      check("reg_we", 32'(we), 32'(x_we));
      check("illegal", 32'(ill), 32'(e_ill));
      check("alu_op_select", 32'(op), 32'(e_op));
      check("alu_sub", 32'(sub), 32'(e_sub));
      check("rd_addr", 32'(rd), 32'(e_rd));
      check("rs_addr", 32'(rs), 32'(e_rs));
      check("instr_count", 32'(cnt), 32'(count % 65536));
      check("instr_count_w2", 32'(cnt2), 32'(count % 4));

      if (x_we) have = 1'b0;

      rst = 1'b0;
      if (dq.size() > 0) begin
        instr_valid = 1'b1;
        instruction = dq[0];
        if (have && cur_opc == 5 && k == 4 && !div_rst_done) begin
          rst = 1'b1;
          div_rst_done = 1'b1;
        end
      end else begin
        instr_valid = ($urandom_range(0, 3) != 0);
        opc = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 6));
        instruction = {4'(opc), 4'($urandom_range(0, 15))};
        if ($urandom_range(0, 79) == 0) rst = 1'b1;
      end
      if (have && trap && k >= 6) rst = 1'b1;

      acc = x_rdy && instr_valid && !rst;
      if (acc) begin
        have    = 1'b1;
        t_acc   = n;
        cur_opc = int'(instruction[7:4]);
        len     = (cur_opc == 4 || cur_opc == 5) ? 3 + MULDIV_LAT : 3;
`ifdef ILLEGAL_TRAP_EN
        trap    = (cur_opc > 5);
`else
        trap    = 1'b0;
`endif
        e_op    = (cur_opc <= 5) ? cur_opc : 0;
        e_sub   = (cur_opc == 1) ? 1 : 0;
        e_rd    = int'(instruction[3:2]);
        e_rs    = int'(instruction[1:0]);
        if (dq.size() > 0) void'(dq.pop_front());
      end
      reset    = rst;
      rst_prev = rst;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
